uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte sources. It accepts one byte at a time from the winning requester and drives the transmitter's start/data inputs. It then waits for frame completion and enforces an idle guard interval of baud ticks before the next frame. It sits between the per-function byte producers and the transmitter/baud-generator pair.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width.
- GUARD_TICKS, 2: idle baud ticks inserted after each frame, 0..15.
- TIMEOUT, 4096: clk cycles allowed in WAIT_DONE before abort.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_W  bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is the last of a packet; used only when the lock feature is compiled in.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- tx_start  out  1  one-cycle pulse that starts a frame.
- tx_data  out  DATA_W  byte to the transmitter; stable from GRANT until the next GRANT.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  one-cycle frame-complete pulse.
- baud_tick  in  1  one-cycle baud-rate strobe from the baud generator.
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester.
- err_timeout  out  1  one-cycle pulse when a frame times out.

## Operation
- FSM states: IDLE, GRANT, START, WAIT_DONE, GUARD.
- IDLE:
  - Stays in IDLE while no req_valid is set, or tx_busy=1.
  - Otherwise the winner is the first valid requester at or after rr_ptr, searching upward with wrap. Go to GRANT, register grant_id, and set req_ready[winner].
- GRANT:
  - If req_valid[grant_id]=1, the transfer occurs: tx_data <= req_data[grant_id] and rr_ptr <= (grant_id+1) mod NUM_REQ. Go to START.
  - If req_valid[grant_id]=0 (requester withdrew), there is no transfer and rr_ptr is unchanged. Go to IDLE.
  - req_ready clears on leaving GRANT.
- START: tx_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - On tx_done, go to GUARD.
  - If the cycle counter reaches TIMEOUT-1 without tx_done, pulse err_timeout and go to GUARD.
  - If tx_done and the timeout occur in the same cycle, tx_done wins and there is no error.
- GUARD: counts baud_tick pulses; after GUARD_TICKS ticks, go to IDLE. With GUARD_TICKS=0, go to IDLE the next cycle.
- Requester protocol: hold req_valid and req_data stable until req_ready is seen. Exactly one byte is accepted per req_ready pulse.
- Counter widths: timeout counter $clog2(TIMEOUT) bits; guard counter 4 bits. Both clear on entry to their state.

## Timing
- Reset values: all outputs 0, rr_ptr=0, FSM in IDLE, counters 0.
- Reset asserted mid-frame returns everything to reset values immediately. The transmitter is not informed.
- Latency: a request seen in IDLE at cycle N gives req_ready at N+1 and tx_start at N+2.
- Minimum spacing between tx_start pulses: frame time plus GUARD_TICKS baud ticks plus 3 cycles.
- A baud_tick arriving in the cycle GUARD is entered counts.

## Configuration
- UART_ARB_PKT_LOCK_EN defined: packet lock.
  - After a transfer with req_last[grant_id]=0, the arbiter is locked to grant_id.
  - While locked, IDLE grants only grant_id and waits for its valid. Other requesters are starved.
  - The lock releases after a transfer with req_last=1, on a timeout, or on reset.
- Not defined: req_last is ignored, and every byte is arbitrated independently in round-robin order.

## Structure
- Shared package uart_arb_pkg holds:
  - the state enum (IDLE, GRANT, START, WAIT_DONE, GUARD);
  - localparam widths derived from NUM_REQ and TIMEOUT.
- Sub-module uart_rr_pick: combinational round-robin winner search. Inputs: valid vector and pointer. Outputs: winner index and any-valid flag. It is reusable by the planned receive-side demux.

## Test plan
- Single requester 2 sends 0xA5 with GUARD_TICKS=2 -> req_ready[2] at N+1, tx_start at N+2 with tx_data=0xA5, grant_id=2; IDLE is re-entered after tx_done plus 2 baud_ticks.
- All four requesters valid continuously, bytes 0x10..0x13 -> tx_data order 0x10, 0x11, 0x12, 0x13, 0x10; rr_ptr wraps 3 -> 0.
- tx_done withheld with TIMEOUT=16 -> err_timeout pulses once, 16 cycles after WAIT_DONE entry; the next request is served normally.
- Requester 1 drops valid during GRANT -> no tx_start; rr_ptr is unchanged and requester 1 is granted again on reassertion.
- rst pulled low during WAIT_DONE -> all outputs 0 and IDLE in the same cycle; a new request is accepted after release.
- With UART_ARB_PKT_LOCK_EN: requester 0 sends 3 bytes (last on the third) while requester 3 is valid -> requester 0's three bytes go out consecutively, then requester 3.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter and its
// round-robin picker.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        GUARD     = 3'd4
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 4096;
    localparam int GUARD_W     = 4;

    // Index/counter width for a range of n values; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = idx_width(NUM_REQ_DEF);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or after ptr,
// searching upward with wrap-around.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = NUM_REQ_DEF,
    parameter int W = ID_W_DEF
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walking from the far end backwards lets the last hit be the nearest one.
    always_comb begin
        int k;
        logic [W-1:0] k_idx;
        k     = 0;
        k_idx = '0;
        idx   = ptr;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            k_idx = W'(k);
            if (valid[k_idx]) begin
                idx = k_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_PKT_LOCK_EN to keep the grant on one requester until its req_last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ     = NUM_REQ_DEF,
    parameter int  DATA_W      = 8,
    parameter int  GUARD_TICKS = 2,
    parameter int  TIMEOUT     = TIMEOUT_DEF,
    localparam int ID_W        = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    input  logic                      baud_tick,
    output logic [ID_W-1:0]           grant_id,
    output logic                      err_timeout,
    output arb_state_t                dbg_state
);

    localparam int                 TMO_W      = idx_width(TIMEOUT);
    localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'((GUARD_TICKS > 0) ? GUARD_TICKS - 1 : 0);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [ID_W-1:0]    cand_id;
    logic               cand_ok;
    logic               locked;
    logic               xfer;
    logic               tmo_fire;
    logic               guard_end;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GUARD_W-1:0] guard_cnt;
    logic [DATA_W-1:0]  sel_data;

    uart_rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Handshake: a byte moves on the clk edge where req_valid[i] and req_ready[i]
    // are both high; req_ready is raised only for grant_id and only while in GRANT.
    assign xfer      = (state == GRANT) && req_valid[grant_id];
    assign tmo_fire  = (state == WAIT_DONE) && !tx_done && (tmo_cnt == TMO_LAST);
    assign guard_end = (state == GUARD) &&
                       ((GUARD_TICKS == 0) || (baud_tick && (guard_cnt == GUARD_LAST)));

    // A locked arbiter only considers the requester it is locked to.
    assign cand_id = locked ? grant_id : pick_idx;
    assign cand_ok = locked ? req_valid[grant_id] : pick_any;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cand_ok && !tx_busy) state_nx = GRANT;
            GRANT:     state_nx = xfer ? START : IDLE;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: if (tx_done || tmo_fire) state_nx = GUARD;
            GUARD:     if (guard_end) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = 1'b1;
        end
        tx_start  = (state == START);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id    <= '0;
            rr_ptr      <= '0;
            tx_data     <= '0;
            tmo_cnt     <= '0;
            guard_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= tmo_fire;
            if ((state == IDLE) && (state_nx == GRANT)) begin
                grant_id <= cand_id;
            end
            if (xfer) begin
                tx_data <= sel_data;
                rr_ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
            // START and WAIT_DONE are the sole predecessors of the counted states.
            if (state == START) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == WAIT_DONE) begin
                guard_cnt <= '0;
            end else if ((state == GUARD) && baud_tick) begin
                guard_cnt <= guard_cnt + 1'b1;
            end
        end
    end

`ifdef UART_ARB_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= !req_last[grant_id];
        end else if (tmo_fire) begin
            locked <= 1'b0;
        end
    end
`else
    logic unused_last;
    assign locked      = 1'b0;
    assign unused_last = ^req_last;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round robin, timeout,
// withdraw, busy hold, mid-frame reset and packet (un)locking.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        baud_tick;
    logic [1:0]  grant_id;
    logic        err_timeout;
    arb_state_t  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .GUARD_TICKS (2),
        .TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .baud_tick   (baud_tick),
        .grant_id    (grant_id),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        baud_tick = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Called in the START cycle; returns in IDLE after tx_done and two baud ticks.
    task automatic finish_frame();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done   = 1'b0;
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
        tick();
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset tx_start: got %b expected 0", tx_start); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset tx_data: got %h expected 00", tx_data); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset err_timeout: got %b expected 0", err_timeout); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset state: got %0d expected %0d", dbg_state, IDLE); end
        rst = 1'b1;
        tick();
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL idle no request: got %0d expected %0d", dbg_state, IDLE); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle req_ready: got %b expected 0000", req_ready); end
    endtask

    task automatic test_single();
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        tick();
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single req_ready N+1: got %b expected 0100", req_ready); end
        n_checks++; if (dbg_state !== GRANT) begin n_fail++; $display("FAIL single state N+1: got %0d expected %0d", dbg_state, GRANT); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single tx_start N+2: got %b expected 1", tx_start); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single tx_data: got %h expected a5", tx_data); end
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single grant_id: got %0d expected 2", grant_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single ready cleared: got %b expected 0000", req_ready); end
        tick();
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single tx_start one cycle: got %b expected 0", tx_start); end
        n_checks++; if (dbg_state !== WAIT_DONE) begin n_fail++; $display("FAIL single wait_done: got %0d expected %0d", dbg_state, WAIT_DONE); end
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++; if (dbg_state !== GUARD) begin n_fail++; $display("FAIL single guard entry: got %0d expected %0d", dbg_state, GUARD); end
        repeat (3) tick();
        n_checks++; if (dbg_state !== GUARD) begin n_fail++; $display("FAIL single guard no ticks: got %0d expected %0d", dbg_state, GUARD); end
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
        n_checks++; if (dbg_state !== GUARD) begin n_fail++; $display("FAIL single guard one tick: got %0d expected %0d", dbg_state, GUARD); end
        tick();
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL single idle after two ticks: got %0d expected %0d", dbg_state, IDLE); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single tx_data held: got %h expected a5", tx_data); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [7:0] exp_data;
        apply_reset();
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_rdy  = 4'b0001 << (i % 4);
            exp_data = 8'h10 + 8'(i % 4);
            tick();
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr req_ready #%0d: got %b expected %b", i, req_ready, exp_rdy); end
            tick();
            n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL rr tx_start #%0d: got %b expected 1", i, tx_start); end
            n_checks++; if (tx_data !== exp_data) begin n_fail++; $display("FAIL rr tx_data #%0d: got %h expected %h", i, tx_data, exp_data); end
            n_checks++; if (grant_id !== 2'(i % 4)) begin n_fail++; $display("FAIL rr grant_id #%0d: got %0d expected %0d", i, grant_id, i % 4); end
            finish_frame();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        req_data[15:8] = 8'h11;
        req_valid      = 4'b0010;
        tick();
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL tmo req_ready: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL tmo tx_start: got %b expected 1", tx_start); end
        tick();
        n_checks++; if (dbg_state !== WAIT_DONE) begin n_fail++; $display("FAIL tmo wait_done entry: got %0d expected %0d", dbg_state, WAIT_DONE); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++; if (err_timeout !== (k == 16)) begin n_fail++; $display("FAIL tmo err_timeout at +%0d: got %b expected %b", k, err_timeout, (k == 16)); end
        end
        n_checks++; if (dbg_state !== GUARD) begin n_fail++; $display("FAIL tmo guard after abort: got %0d expected %0d", dbg_state, GUARD); end
        tick();
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo single pulse: got %b expected 0", err_timeout); end
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
        tick();
        n_checks++; if (dbg_state !== GUARD) begin n_fail++; $display("FAIL tmo guard one tick: got %0d expected %0d", dbg_state, GUARD); end
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL tmo back to idle: got %0d expected %0d", dbg_state, IDLE); end
        req_data[31:24] = 8'h33;
        req_valid       = 4'b1000;
        tick();
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL tmo next req_ready: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (tx_data !== 8'h33) begin n_fail++; $display("FAIL tmo next tx_data: got %h expected 33", tx_data); end
        finish_frame();
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo normal frame err: got %b expected 0", err_timeout); end
    endtask

    task automatic test_withdraw();
        req_data[15:8]  = 8'h21;
        req_data[31:24] = 8'h43;
        req_valid       = 4'b0010;
        tick();
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wd req_ready: got %b expected 0010", req_ready); end
        req_valid = 4'b0000;
        tick();
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL wd no tx_start: got %b expected 0", tx_start); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL wd back to idle: got %0d expected %0d", dbg_state, IDLE); end
        n_checks++; if (tx_data !== 8'h33) begin n_fail++; $display("FAIL wd tx_data untouched: got %h expected 33", tx_data); end
        req_valid = 4'b1010;
        tick();
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wd regrant 1: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b1000;
        n_checks++; if (tx_data !== 8'h21) begin n_fail++; $display("FAIL wd tx_data: got %h expected 21", tx_data); end
        finish_frame();
        tick();
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wd then 3: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (tx_data !== 8'h43) begin n_fail++; $display("FAIL wd tx_data 3: got %h expected 43", tx_data); end
        finish_frame();
    endtask

    task automatic test_busy_hold();
        req_data[7:0] = 8'h5C;
        req_valid     = 4'b0001;
        tx_busy       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL busy hold #%0d: got %b expected 0000", k, req_ready); end
        end
        tx_busy = 1'b0;
        tick();
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL busy released: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (tx_data !== 8'h5C) begin n_fail++; $display("FAIL busy tx_data: got %h expected 5c", tx_data); end
        finish_frame();
    endtask

    task automatic test_reset_mid_frame();
        req_data[23:16] = 8'h5A;
        req_valid       = 4'b0100;
        tick();
        tick();
        req_valid = 4'b0000;
        tick();
        n_checks++; if (dbg_state !== WAIT_DONE) begin n_fail++; $display("FAIL mrst in wait_done: got %0d expected %0d", dbg_state, WAIT_DONE); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL mrst state: got %0d expected %0d", dbg_state, IDLE); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mrst tx_data: got %h expected 00", tx_data); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mrst grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL mrst tx_start: got %b expected 0", tx_start); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mrst req_ready: got %b expected 0000", req_ready); end
        tick();
        tick();
        rst       = 1'b1;
        req_valid = 4'b0100;
        tick();
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mrst new req_ready: got %b expected 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL mrst new tx_start: got %b expected 1", tx_start); end
        n_checks++; if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL mrst new tx_data: got %h expected 5a", tx_data); end
        finish_frame();
    endtask

    task automatic test_packet();
        logic [1:0] exp_id [4];
        logic [7:0] exp_dat [4];
        logic [3:0] seen_rdy;
        int         idx0;
`ifdef UART_ARB_PKT_LOCK_EN
        exp_id  = '{2'd0, 2'd0, 2'd0, 2'd3};
        exp_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hD3};
`else
        exp_id  = '{2'd0, 2'd3, 2'd0, 2'd0};
        exp_dat = '{8'hA0, 8'hD3, 8'hA1, 8'hA2};
`endif
        apply_reset();
        idx0            = 0;
        req_data[7:0]   = 8'hA0;
        req_data[31:24] = 8'hD3;
        req_last        = 4'b1000;
        req_valid       = 4'b1001;
        for (int f = 0; f < 4; f++) begin
            tick();
            seen_rdy = req_ready;
            n_checks++; if (req_ready !== (4'b0001 << exp_id[f])) begin n_fail++; $display("FAIL pkt req_ready #%0d: got %b expected %b", f, req_ready, 4'b0001 << exp_id[f]); end
            tick();
            n_checks++; if (tx_data !== exp_dat[f]) begin n_fail++; $display("FAIL pkt tx_data #%0d: got %h expected %h", f, tx_data, exp_dat[f]); end
            n_checks++; if (grant_id !== exp_id[f]) begin n_fail++; $display("FAIL pkt grant_id #%0d: got %0d expected %0d", f, grant_id, exp_id[f]); end
            if (seen_rdy[0]) begin
                idx0++;
                if (idx0 == 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_data[7:0] = 8'hA0 + 8'(idx0);
                    req_last[0]   = (idx0 == 2);
                end
            end
            if (seen_rdy[3]) begin
                req_valid[3] = 1'b0;
            end
            finish_frame();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_busy_hold();
        test_reset_mid_frame();
        test_packet();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
